// File: rtl/system_top_mul_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// Contents: operand/product widths, default requester count and id width,
// the operand-pair and response record types, and the pointer wrap helper.
package system_top_mul_pkg;

   localparam int DIN0_W       = 16;
   localparam int DIN1_W       = 11;
   localparam int DOUT_W       = DIN0_W + DIN1_W;
   localparam int NUM_REQ_DFLT = 4;
   localparam int ID_W_DFLT    = 2;

   typedef struct packed {
      logic signed [DIN0_W-1:0] a;
      logic signed [DIN1_W-1:0] b;
   } mul_req_t;

   typedef struct packed {
      logic [ID_W_DFLT-1:0]     id;
      logic signed [DOUT_W-1:0] dout;
   } mul_rsp_t;

   // Next round-robin position after index idx among n requesters.
   function automatic int ptr_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/system_top_mul_16s_11s.sv
// Shared signed 16 x 11 -> 27 multiplier, purely combinational.
// Ports: a (signed 16b operand), b (signed 11b operand), p (signed full-width product).
module system_top_mul_16s_11s
   import system_top_mul_pkg::*;
(
   input  logic signed [DIN0_W-1:0] a,
   input  logic signed [DIN1_W-1:0] b,
   output logic signed [DOUT_W-1:0] p
);

   // Full-width product; 16+11 bits cannot overflow.
   assign p = a * b;

endmodule

// File: rtl/system_top_rr_arb.sv
// Round-robin priority picker.
// Ports: req (request vector), ptr (highest-priority index), en (grant enable),
//        gnt (one-hot grant or zero), gnt_id (encoded grant index, 0 when no grant).
module system_top_rr_arb
   import system_top_mul_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DFLT,
   parameter int ID_W    = ID_W_DFLT
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id
);

   logic found_s;
   logic hit_s;

   // Walk priority levels ptr, ptr+1, ... (mod NUM_REQ); first requester found wins.
   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            hit_s   = en && !found_s && req[i] && (i == ((int'(ptr) + k) % NUM_REQ));
            gnt[i]  = gnt[i] | hit_s;
            gnt_id  = hit_s ? ID_W'(i) : gnt_id;
            found_s = found_s | hit_s;
         end
      end
   end

endmodule

// File: rtl/system_top_mul_share_arb.sv
// Round-robin sequencer sharing one signed multiplier among NUM_REQ requesters.
// S1 registers the granted operand pair and id, S2 registers the product;
// the response port is driven straight from S2.
// Ports: ap_clk/ap_rst_n (clock, sync active-low reset), req_valid/req_ready and
//        req_din0/req_din1 (per-requester operand handshake, flattened slices),
//        rsp_valid/rsp_ready/rsp_id/rsp_dout (product response), busy (pipeline occupied).
module system_top_mul_share_arb
   import system_top_mul_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DFLT,
   parameter int ID_W    = ID_W_DFLT
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*DIN0_W-1:0]   req_din0,
   input  logic [NUM_REQ*DIN1_W-1:0]   req_din1,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [ID_W-1:0]             rsp_id,
   output logic [DOUT_W-1:0]           rsp_dout,
   output logic                        busy
);

   logic                     s1_vld_q,  s1_vld_d;
   mul_req_t                 s1_op_q,   s1_op_d;
   logic [ID_W-1:0]          s1_id_q,   s1_id_d;
   logic                     s2_vld_q,  s2_vld_d;
   logic signed [DOUT_W-1:0] s2_dout_q, s2_dout_d;
   logic [ID_W-1:0]          s2_id_q,   s2_id_d;
   logic [ID_W-1:0]          rr_ptr_q,  rr_ptr_d;

   logic                     adv1_s;
   logic                     adv2_s;
   logic                     xfer_s;
   logic [NUM_REQ-1:0]       gnt_s;
   logic [ID_W-1:0]          gnt_id_s;
   mul_req_t                 sel_op_s;
   logic signed [DOUT_W-1:0] prod_s;

   // Stage advance conditions: a stage may load when it is empty or the one after it moves.
   always_comb begin
      adv2_s = !s2_vld_q || rsp_ready;
      adv1_s = !s1_vld_q || adv2_s;
   end

   // Grants are suppressed during reset so nothing is reported as accepted.
   system_top_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .en      (adv1_s & ap_rst_n),
      .gnt     (gnt_s),
      .gnt_id  (gnt_id_s)
   );

   assign req_ready = gnt_s;
   assign xfer_s    = |(req_valid & gnt_s);

   // One-hot AND-OR mux of the granted requester's operand slices.
   always_comb begin
      sel_op_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_op_s.a = sel_op_s.a | ({DIN0_W{gnt_s[i]}} & req_din0[i*DIN0_W +: DIN0_W]);
         sel_op_s.b = sel_op_s.b | ({DIN1_W{gnt_s[i]}} & req_din1[i*DIN1_W +: DIN1_W]);
      end
   end

   system_top_mul_16s_11s u_mul (
      .a (s1_op_q.a),
      .b (s1_op_q.b),
      .p (prod_s)
   );

   // S1 load/clear and pointer advance; the pointer moves only on an accepted transfer.
   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_op_d  = s1_op_q;
      s1_id_d  = s1_id_q;
      rr_ptr_d = rr_ptr_q;
      if (xfer_s) begin
         s1_vld_d = 1'b1;
         s1_op_d  = sel_op_s;
         s1_id_d  = gnt_id_s;
         rr_ptr_d = ID_W'(ptr_inc(int'(gnt_id_s), NUM_REQ));
      end else if (adv1_s) begin
         s1_vld_d = 1'b0;
      end else begin
         s1_vld_d = s1_vld_q;
      end
   end

   // S2 takes the product when it advances; data holds otherwise so rsp_* stay stable.
   always_comb begin
      s2_vld_d  = s2_vld_q;
      s2_dout_d = s2_dout_q;
      s2_id_d   = s2_id_q;
      if (adv2_s && s1_vld_q) begin
         s2_vld_d  = 1'b1;
         s2_dout_d = prod_s;
         s2_id_d   = s1_id_q;
      end else if (adv2_s) begin
         s2_vld_d  = 1'b0;
      end else begin
         s2_vld_d  = s2_vld_q;
      end
   end

   // Pipeline and pointer registers; reset discards anything in flight.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         s1_vld_q  <= 1'b0;
         s1_op_q   <= '0;
         s1_id_q   <= '0;
         s2_vld_q  <= 1'b0;
         s2_dout_q <= '0;
         s2_id_q   <= '0;
         rr_ptr_q  <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_op_q   <= s1_op_d;
         s1_id_q   <= s1_id_d;
         s2_vld_q  <= s2_vld_d;
         s2_dout_q <= s2_dout_d;
         s2_id_q   <= s2_id_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign rsp_valid = s2_vld_q;
   assign rsp_id    = s2_id_q;
   assign rsp_dout  = s2_dout_q;
   assign busy      = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_system_top_mul_share_arb.sv
// Bench for system_top_mul_share_arb: constant product table, directed ordering,
// back-pressure, fairness and reset sequences, then random traffic, all checked
// against a transaction-level model (in-flight queue plus round-robin pointer).
module tb_system_top_mul_share_arb;

   localparam int NR = 4;

   logic        clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [3:0]  req_valid = 4'h0;
   logic [3:0]  req_ready;
   logic [63:0] req_din0 = 64'h0;
   logic [43:0] req_din1 = 44'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [1:0]  rsp_id;
   logic [26:0] rsp_dout;
   logic        busy;

   system_top_mul_share_arb #(.NUM_REQ(4), .ID_W(2)) dut (
      .ap_clk    (clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_din0  (req_din0),
      .req_din1  (req_din1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_dout  (rsp_dout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: accepted ops in order with the edge index at which they were accepted.
   typedef struct { int id; int prod; int acc; } item_t;
   item_t m_q[$];
   int    m_ptr = 0;
   int    edge_cnt = 0;
   int    last_gid = -1;

   typedef struct { int id; logic [15:0] a; logic [10:0] b; int exp; } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: check outputs against model, drive inputs, check grant, advance model.
   task automatic step(input logic [3:0] v, input logic rr, input logic [63:0] d0, input logic [43:0] d1);
      bit         exp_v;
      logic [3:0] exp_g;
      int         gid;
      int         a;
      int         b;
      item_t      it;
      @(negedge clk);
      exp_v = (m_q.size() > 0) && (m_q[0].acc < edge_cnt);
      chk("rsp_valid", int'(rsp_valid), int'(exp_v));
      if (exp_v) begin
         chk("rsp_id", int'(rsp_id), m_q[0].id);
         chk("rsp_dout", int'($signed(rsp_dout)), m_q[0].prod);
      end
      chk("busy", int'(busy), int'(m_q.size() > 0));
      req_valid = v;
      rsp_ready = rr;
      req_din0  = d0;
      req_din1  = d1;
      #1;
      gid = -1;
      if (m_q.size() < 2 || rr) begin
         for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (gid < 0 && ((v >> i) & 4'd1) != 4'd0) gid = i;
         end
      end
      exp_g = (gid >= 0) ? 4'(32'd1 << gid) : 4'd0;
      chk("req_ready", int'(req_ready), int'(exp_g));
      last_gid = gid;
      @(posedge clk);
      if (exp_v && rr) void'(m_q.pop_front());
      if (gid >= 0) begin
         a = int'($signed(16'(d0 >> (16 * gid))));
         b = int'($signed(11'(d1 >> (11 * gid))));
         it.id   = gid;
         it.prod = a * b;
         it.acc  = edge_cnt + 1;
         m_q.push_back(it);
         m_ptr = (gid + 1) % NR;
      end
      edge_cnt = edge_cnt + 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      ap_rst_n  = 1'b0;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      #1 chk("rst_req_ready", int'(req_ready), 0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_rsp_dout", int'($signed(rsp_dout)), 0);
      #1 chk("rst_req_ready_hold", int'(req_ready), 0);
      req_valid = 4'h0;
      ap_rst_n  = 1'b1;
      m_q.delete();
      m_ptr = 0;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_cnt;
      tbl[0] = '{0, 16'h7FFF, 11'h400, -33553408};
      tbl[1] = '{2, 16'h8000, 11'h400,  33554432};
      tbl[2] = '{1, 16'h0000, 11'h7FF,  0};
      tbl[3] = '{3, 16'hFFFF, 11'h7FF,  1};
      tbl[4] = '{1, 16'h7FFF, 11'h3FF,  33520641};
      tbl[5] = '{3, 16'h8000, 11'h3FF, -33521664};

      do_reset();

      // Constant product table: single op, response visible two edges after acceptance.
      for (int k = 0; k < 6; k++) begin
         step(4'(32'd1 << tbl[k].id), 1'b1,
              64'(tbl[k].a) << (16 * tbl[k].id), 44'(tbl[k].b) << (11 * tbl[k].id));
         chk("tbl_grant", last_gid, tbl[k].id);
         step(4'h0, 1'b1, 64'h0, 44'h0);
         #1;
         chk("tbl_rsp_valid", int'(rsp_valid), 1);
         chk("tbl_rsp_id", int'(rsp_id), tbl[k].id);
         chk("tbl_rsp_dout", int'($signed(rsp_dout)), tbl[k].exp);
      end

      // All requesters valid: strict rotation 0,1,2,3,...
      do_reset();
      for (int k = 0; k < 8; k++) begin
         step(4'hF, 1'b1, rnd64(), 44'(rnd64()));
         chk("rr_order", last_gid, k % 4);
      end
      for (int k = 0; k < 3; k++) step(4'h0, 1'b1, 64'h0, 44'h0);

      // Back-pressure: exactly two ops buffered while the response is held.
      acc_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         step(4'b0100, 1'b0, rnd64(), 44'(rnd64()));
         if (last_gid == 2) acc_cnt = acc_cnt + 1;
      end
      chk("bp_buffered", acc_cnt, 2);
      for (int k = 0; k < 4; k++) step(4'h0, 1'b1, 64'h0, 44'h0);

      // Fairness: pointer at 2 with req1/req3 pending.
      do_reset();
      step(4'b0010, 1'b1, rnd64(), 44'(rnd64()));
      chk("fair_first", last_gid, 1);
      step(4'b1010, 1'b1, rnd64(), 44'(rnd64()));
      chk("fair_req3", last_gid, 3);
      step(4'b1010, 1'b1, rnd64(), 44'(rnd64()));
      chk("fair_req1", last_gid, 1);
      step(4'hF, 1'b1, rnd64(), 44'(rnd64()));
      chk("fair_ptr2", last_gid, 2);
      for (int k = 0; k < 3; k++) step(4'h0, 1'b1, 64'h0, 44'h0);

      // Reset with both stages full.
      for (int k = 0; k < 3; k++) step(4'hF, 1'b0, rnd64(), 44'(rnd64()));
      #1 chk("midop_busy", int'(busy), 1);
      do_reset();
      step(4'hF, 1'b1, rnd64(), 44'(rnd64()));
      chk("midop_ptr0", last_gid, 0);
      for (int k = 0; k < 3; k++) step(4'h0, 1'b1, 64'h0, 44'h0);

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
              rnd64(), 44'(rnd64()));
      end
      for (int k = 0; k < 4; k++) step(4'h0, 1'b1, 64'h0, 44'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
